vliw_bypass_ctrl: RTL and testbench

VLIW_BYPASS_CTRL -- requirements
Module: vliw_bypass_ctrl

---
 rtl/vliw_bypass_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vliw_bypass_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bypass_ctrl.sv
// Lockstep VLIW bypass control: per-lane E/M/W tracking, operand forwarding and load-use detection.
// Define VLIW_BUNDLE_RAW_CHECK_EN to build the intra-bundle RAW comparator driving BundleHazardD.
module vliw_bypass_ctrl #(
    parameter int LANES = 4,
    parameter int XLEN  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          StallE,
    input  logic                          StallM,
    input  logic                          StallW,
    input  logic                          FlushE,
    input  logic                          FlushM,
    input  logic                          FlushW,
    input  logic [LANES*5-1:0]            Rs1D,
    input  logic [LANES*5-1:0]            Rs2D,
    input  logic [LANES*5-1:0]            RdD,
    input  logic [LANES-1:0]              RegWriteD,
    input  logic [LANES-1:0]              LoadD,
    input  logic [LANES*XLEN-1:0]         RFSrcAE,
    input  logic [LANES*XLEN-1:0]         RFSrcBE,
    input  logic [LANES*XLEN-1:0]         IFResultM,
    input  logic [LANES*XLEN-1:0]         ResultW,
    output logic [LANES*XLEN-1:0]         ForwardedSrcAE,
    output logic [LANES*XLEN-1:0]         ForwardedSrcBE,
    output logic [LANES*2-1:0]            ForwardAE,
    output logic [LANES*2-1:0]            ForwardBE,
    output logic [LANES*$clog2(LANES)-1:0] FwdLaneAE,
    output logic [LANES*$clog2(LANES)-1:0] FwdLaneBE,
    output logic [LANES*5-1:0]            RdM,
    output logic [LANES*5-1:0]            RdW,
    output logic [LANES-1:0]              RegWriteM,
    output logic [LANES-1:0]              RegWriteW,
    output logic                          LoadStallD,
    output logic                          BundleHazardD
);
    localparam int LW = $clog2(LANES);

    logic [LANES*5-1:0] Rs1E, Rs2E, RdE;
    logic [LANES-1:0]   RegWriteE, LoadE;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            RegWriteE <= '0;
            LoadE     <= '0;
            RdM       <= '0;
            RegWriteM <= '0;
            RdW       <= '0;
            RegWriteW <= '0;
        end else begin
            // A flushed stage becomes a bubble even when its stall is also asserted.
            if (FlushE) begin
                Rs1E      <= '0;
                Rs2E      <= '0;
                RdE       <= '0;
                RegWriteE <= '0;
                LoadE     <= '0;
            end else if (!StallE) begin
                Rs1E      <= Rs1D;
                Rs2E      <= Rs2D;
                RdE       <= RdD;
                RegWriteE <= RegWriteD;
                LoadE     <= LoadD;
            end

            if (FlushM) begin
                RdM       <= '0;
                RegWriteM <= '0;
            end else if (!StallM) begin
                RdM       <= RdE;
                RegWriteM <= RegWriteE;
            end

            if (FlushW) begin
                RdW       <= '0;
                RegWriteW <= '0;
            end else if (!StallW) begin
                RdW       <= RdM;
                RegWriteW <= RegWriteM;
            end
        end
    end

    // Returns {forward code, producing lane}; later (higher) lanes override, and M overrides W.
    function automatic logic [LW+1:0] select_src(
        input logic [4:0]         src,
        input logic [LANES*5-1:0] rd_m,
        input logic [LANES-1:0]   we_m,
        input logic [LANES*5-1:0] rd_w,
        input logic [LANES-1:0]   we_w
    );
        logic [1:0]    fwd;
        logic [LW-1:0] lane;
        fwd  = 2'b00;
        lane = '0;
        if (src != 5'd0) begin
            for (int k = 0; k < LANES; k++) begin
                if (we_w[k] && rd_w[5*k +: 5] == src) begin
                    fwd  = 2'b01;
                    lane = LW'(k);
                end
            end
            for (int k = 0; k < LANES; k++) begin
                if (we_m[k] && rd_m[5*k +: 5] == src) begin
                    fwd  = 2'b10;
                    lane = LW'(k);
                end
            end
        end
        return {fwd, lane};
    endfunction

    function automatic logic [XLEN-1:0] mux_src(
        input logic [1:0]            fwd,
        input logic [LW-1:0]         lane,
        input logic [XLEN-1:0]       rf,
        input logic [LANES*XLEN-1:0] res_m,
        input logic [LANES*XLEN-1:0] res_w
    );
        case (fwd)
            2'b10:   return res_m[XLEN*int'(lane) +: XLEN];
            2'b01:   return res_w[XLEN*int'(lane) +: XLEN];
            default: return rf;
        endcase
    endfunction

    // NOTE: every combinational output gets a default before the loops, so no latch can be inferred.
    always_comb begin
        ForwardAE = '0;
        ForwardBE = '0;
        FwdLaneAE = '0;
        FwdLaneBE = '0;
        for (int i = 0; i < LANES; i++) begin
            {ForwardAE[2*i +: 2], FwdLaneAE[LW*i +: LW]} =
                select_src(Rs1E[5*i +: 5], RdM, RegWriteM, RdW, RegWriteW);
            {ForwardBE[2*i +: 2], FwdLaneBE[LW*i +: LW]} =
                select_src(Rs2E[5*i +: 5], RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    always_comb begin
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;
        for (int i = 0; i < LANES; i++) begin
            ForwardedSrcAE[XLEN*i +: XLEN] = mux_src(ForwardAE[2*i +: 2], FwdLaneAE[LW*i +: LW],
                                                     RFSrcAE[XLEN*i +: XLEN], IFResultM, ResultW);
            ForwardedSrcBE[XLEN*i +: XLEN] = mux_src(ForwardBE[2*i +: 2], FwdLaneBE[LW*i +: LW],
                                                     RFSrcBE[XLEN*i +: XLEN], IFResultM, ResultW);
        end
    end

    // Any load in E whose destination is read anywhere in the Decode bundle.
    always_comb begin
        LoadStallD = 1'b0;
        for (int e = 0; e < LANES; e++) begin
            for (int d = 0; d < LANES; d++) begin
                if (LoadE[e] && RegWriteE[e] && RdE[5*e +: 5] != 5'd0 &&
                    (RdE[5*e +: 5] == Rs1D[5*d +: 5] || RdE[5*e +: 5] == Rs2D[5*d +: 5]))
                    LoadStallD = 1'b1;
            end
        end
    end

`ifdef VLIW_BUNDLE_RAW_CHECK_EN
    always_comb begin
        BundleHazardD = 1'b0;
        for (int j = 1; j < LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                if (RegWriteD[i] &&
                    ((Rs1D[5*j +: 5] != 5'd0 && Rs1D[5*j +: 5] == RdD[5*i +: 5]) ||
                     (Rs2D[5*j +: 5] != 5'd0 && Rs2D[5*j +: 5] == RdD[5*i +: 5])))
                    BundleHazardD = 1'b1;
            end
        end
    end
`else
    assign BundleHazardD = 1'b0;
`endif

endmodule

// File: tb/tb_vliw_bypass_ctrl.sv
// Bench for vliw_bypass_ctrl: table-driven forwarding vectors with a scoreboard queue,
// plus hand sequences for load-use, stall/flush, bundle RAW and mid-stream reset.
module tb_vliw_bypass_ctrl;
    localparam int LANES = 4;
    localparam int XLEN  = 64;
    localparam int LW    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  StallE, StallM, StallW, FlushE, FlushM, FlushW;
    logic [LANES*5-1:0]    Rs1D, Rs2D, RdD;
    logic [LANES-1:0]      RegWriteD, LoadD;
    logic [LANES*XLEN-1:0] RFSrcAE, RFSrcBE, IFResultM, ResultW;
    logic [LANES*XLEN-1:0] ForwardedSrcAE, ForwardedSrcBE;
    logic [LANES*2-1:0]    ForwardAE, ForwardBE;
    logic [LANES*LW-1:0]   FwdLaneAE, FwdLaneBE;
    logic [LANES*5-1:0]    RdM, RdW;
    logic [LANES-1:0]      RegWriteM, RegWriteW;
    logic                  LoadStallD, BundleHazardD;

    vliw_bypass_ctrl #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LoadD(LoadD),
        .RFSrcAE(RFSrcAE), .RFSrcBE(RFSrcBE), .IFResultM(IFResultM), .ResultW(ResultW),
        .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .FwdLaneAE(FwdLaneAE), .FwdLaneBE(FwdLaneBE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadStallD(LoadStallD), .BundleHazardD(BundleHazardD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][4:0] w_rd;
        logic [3:0]      w_we;
        logic [3:0][4:0] m_rd;
        logic [3:0]      m_we;
        logic [3:0][4:0] rs1;
        logic [3:0][4:0] rs2;
        logic [XLEN-1:0] m_base;
        logic [XLEN-1:0] w_base;
        logic [1:0]      ha_f, hb_f;   // hand-derived lane-0 expectations
        logic [1:0]      ha_l, hb_l;
        logic [XLEN-1:0] ha_d, hb_d;
    } vec_t;

    typedef struct {
        logic [1:0]      fa [4];
        logic [1:0]      fb [4];
        logic [1:0]      la [4];
        logic [1:0]      lb [4];
        logic [XLEN-1:0] da [4];
        logic [XLEN-1:0] db [4];
    } exp_t;

    localparam int NV = 7;
    vec_t tbl [NV];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [19:0] rs1, input logic [19:0] rs2, input logic [19:0] rd,
                         input logic [3:0] we, input logic [3:0] ld);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = we; LoadD = ld;
    endtask

    task automatic drain();
        set_d('0, '0, '0, '0, '0);
        repeat (3) tick();
    endtask

    function automatic vec_t mk(
        input logic [19:0] w_rd, input logic [3:0] w_we, input logic [19:0] m_rd, input logic [3:0] m_we,
        input logic [19:0] rs1, input logic [19:0] rs2, input logic [XLEN-1:0] m_base, input logic [XLEN-1:0] w_base,
        input logic [1:0] ha_f, input logic [1:0] ha_l, input logic [XLEN-1:0] ha_d,
        input logic [1:0] hb_f, input logic [1:0] hb_l, input logic [XLEN-1:0] hb_d);
        vec_t v;
        v.w_rd = w_rd; v.w_we = w_we; v.m_rd = m_rd; v.m_we = m_we;
        v.rs1 = rs1; v.rs2 = rs2; v.m_base = m_base; v.w_base = w_base;
        v.ha_f = ha_f; v.ha_l = ha_l; v.ha_d = ha_d;
        v.hb_f = hb_f; v.hb_l = hb_l; v.hb_d = hb_d;
        return v;
    endfunction

    // Reference: scan M from the top lane down, then W, first hit wins.
    task automatic model(input logic [4:0] src, input vec_t v, input logic [XLEN-1:0] rf,
                         output logic [1:0] f, output logic [1:0] l, output logic [XLEN-1:0] d);
        f = 2'b00; l = 2'd0; d = rf;
        if (src != 5'd0) begin
            for (int k = 3; k >= 0; k--)
                if (f == 2'b00 && v.m_we[k] && v.m_rd[k] == src) begin
                    f = 2'b10; l = k[1:0]; d = v.m_base + 64'(k);
                end
            for (int k = 3; k >= 0; k--)
                if (f == 2'b00 && v.w_we[k] && v.w_rd[k] == src) begin
                    f = 2'b01; l = k[1:0]; d = v.w_base + 64'(k);
                end
        end
    endtask

    function automatic logic [XLEN-1:0] rf_a(input int k); return 64'hF000 + 64'(k); endfunction
    function automatic logic [XLEN-1:0] rf_b(input int k); return 64'hE000 + 64'(k); endfunction

    initial begin
        vec_t v;
        exp_t e;
        logic bh_exp;

        // Rd/Rs fields are {lane3, lane2, lane1, lane0}
        tbl[0] = mk('0, 4'b0000, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0100,
                    {5'd5, 5'd0, 5'd0, 5'd5}, '0, 64'hA8, 64'h0,
                    2'b10, 2'd2, 64'hAA, 2'b00, 2'd0, 64'hE000);
        tbl[1] = mk({5'd7, 5'd0, 5'd0, 5'd0}, 4'b1000, {5'd0, 5'd0, 5'd7, 5'd0}, 4'b0010,
                    {5'd0, 5'd7, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd0, 5'd7}, 64'h10, 64'h1F,
                    2'b00, 2'd0, 64'hF000, 2'b10, 2'd1, 64'h11);
        tbl[2] = mk('0, 4'b0000, {5'd9, 5'd0, 5'd9, 5'd0}, 4'b1010,
                    {5'd0, 5'd0, 5'd9, 5'd9}, {5'd9, 5'd0, 5'd0, 5'd9}, 64'h300, 64'h0,
                    2'b10, 2'd3, 64'h303, 2'b10, 2'd3, 64'h303);
        tbl[3] = mk({5'd0, 5'd12, 5'd0, 5'd0}, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0}, 4'b0000,
                    {5'd0, 5'd0, 5'd0, 5'd12}, {5'd0, 5'd0, 5'd12, 5'd0}, 64'h400, 64'h500,
                    2'b01, 2'd2, 64'h502, 2'b00, 2'd0, 64'hE000);
        tbl[4] = mk('0, 4'b0010, '0, 4'b0001, '0, '0, 64'h600, 64'h650,
                    2'b00, 2'd0, 64'hF000, 2'b00, 2'd0, 64'hE000);
        tbl[5] = mk({5'd0, 5'd0, 5'd0, 5'd8}, 4'b0001, {5'd8, 5'd0, 5'd0, 5'd0}, 4'b0000,
                    {5'd8, 5'd0, 5'd0, 5'd8}, {5'd0, 5'd0, 5'd0, 5'd3}, 64'h680, 64'h700,
                    2'b01, 2'd0, 64'h700, 2'b00, 2'd0, 64'hE000);
        tbl[6] = mk({5'd0, 5'd13, 5'd0, 5'd13}, 4'b0101, {5'd0, 5'd0, 5'd14, 5'd0}, 4'b0010,
                    {5'd13, 5'd0, 5'd0, 5'd14}, {5'd0, 5'd14, 5'd0, 5'd13}, 64'h800, 64'h900,
                    2'b10, 2'd1, 64'h801, 2'b01, 2'd2, 64'h902);

        reset = 1'b1;
        {StallE, StallM, StallW, FlushE, FlushM, FlushW} = '0;
        set_d('0, '0, '0, '0, '0);
        IFResultM = '0; ResultW = '0;
        for (int k = 0; k < LANES; k++) begin
            RFSrcAE[XLEN*k +: XLEN] = rf_a(k);
            RFSrcBE[XLEN*k +: XLEN] = rf_b(k);
        end

        #12;
        check("rst_fwd", {ForwardAE, ForwardBE, FwdLaneAE, FwdLaneBE}, 64'h0);
        check("rst_rd", {RdM, RdW, RegWriteM, RegWriteW, LoadStallD}, 64'h0);
        @(negedge clk) reset = 1'b0;
        tick();
        check("post_rst_regs", {RdM, RdW, RegWriteM, RegWriteW}, 64'h0);
        check("post_rst_src", ForwardedSrcAE[XLEN-1:0], 64'hF000);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            set_d('0, '0, v.w_rd, v.w_we, '0);
            tick();
            set_d('0, '0, v.m_rd, v.m_we, '0);
            tick();
            set_d(v.rs1, v.rs2, '0, '0, '0);
            for (int k = 0; k < LANES; k++) begin
                IFResultM[XLEN*k +: XLEN] = v.m_base + 64'(k);
                ResultW[XLEN*k +: XLEN]   = v.w_base + 64'(k);
                model(v.rs1[k], v, rf_a(k), e.fa[k], e.la[k], e.da[k]);
                model(v.rs2[k], v, rf_b(k), e.fb[k], e.lb[k], e.db[k]);
            end
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            for (int k = 0; k < LANES; k++) begin
                check($sformatf("v%0d_fa%0d", i, k), ForwardAE[2*k +: 2], e.fa[k]);
                check($sformatf("v%0d_fb%0d", i, k), ForwardBE[2*k +: 2], e.fb[k]);
                check($sformatf("v%0d_la%0d", i, k), FwdLaneAE[LW*k +: LW], e.la[k]);
                check($sformatf("v%0d_lb%0d", i, k), FwdLaneBE[LW*k +: LW], e.lb[k]);
                check($sformatf("v%0d_da%0d", i, k), ForwardedSrcAE[XLEN*k +: XLEN], e.da[k]);
                check($sformatf("v%0d_db%0d", i, k), ForwardedSrcBE[XLEN*k +: XLEN], e.db[k]);
            end
            check($sformatf("v%0d_hand_a", i), {ForwardAE[1:0], FwdLaneAE[1:0], ForwardedSrcAE[31:0]},
                  {v.ha_f, v.ha_l, v.ha_d[31:0]});
            check($sformatf("v%0d_hand_b", i), {ForwardBE[1:0], FwdLaneBE[1:0], ForwardedSrcBE[31:0]},
                  {v.hb_f, v.hb_l, v.hb_d[31:0]});
        end

        // Load-use: load to x4 on E lane 0
        drain();
        set_d('0, '0, {5'd0, 5'd0, 5'd0, 5'd4}, 4'b0001, 4'b0001);
        tick();
        set_d('0, {5'd4, 5'd0, 5'd0, 5'd0}, '0, '0, '0);
        #1 check("lu_rs2_lane3", LoadStallD, 1'b1);
        set_d({5'd0, 5'd0, 5'd4, 5'd0}, '0, '0, '0, '0);
        #1 check("lu_rs1_lane1", LoadStallD, 1'b1);
        set_d({5'd1, 5'd2, 5'd3, 5'd5}, {5'd8, 5'd6, 5'd7, 5'd9}, '0, '0, '0);
        #1 check("lu_nomatch", LoadStallD, 1'b0);
        set_d('0, '0, '0, 4'b0001, 4'b0001);
        tick();
        set_d('0, '0, '0, '0, '0);
        #1 check("lu_x0", LoadStallD, 1'b0);

        // Flush wins over stall on M
        drain();
        set_d('0, '0, {5'd0, 5'd0, 5'd6, 5'd0}, 4'b0010, '0);
        tick();
        set_d({5'd0, 5'd0, 5'd0, 5'd6}, '0, '0, '0, '0);
        StallM = 1'b1; FlushM = 1'b1;
        tick();
        StallM = 1'b0; FlushM = 1'b0;
        check("flush_m_regs", {RdM, RegWriteM}, 64'h0);
        check("flush_m_nofwd", {ForwardAE[1:0], ForwardedSrcAE[31:0]}, {2'b00, 32'hF000});

        // Stall alone holds M while W still advances
        drain();
        set_d('0, '0, {5'd0, 5'd0, 5'd6, 5'd0}, 4'b0010, '0);
        tick();
        set_d('0, '0, '0, '0, '0);
        tick();
        StallM = 1'b1;
        tick();
        StallM = 1'b0;
        check("stall_m_hold", {RdM, RegWriteM}, {5'd0, 5'd0, 5'd6, 5'd0, 4'b0010});

        // Flushed E bubble reaches M as zero
        drain();
        set_d('0, '0, {5'd11, 5'd0, 5'd0, 5'd0}, 4'b1000, '0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        set_d('0, '0, '0, '0, '0);
        tick();
        check("flush_e_bubble", {RdM, RegWriteM}, 64'h0);

        // Intra-bundle RAW: lane 0 writes x3, lane 1 reads it
`ifdef VLIW_BUNDLE_RAW_CHECK_EN
        bh_exp = 1'b1;
`else
        bh_exp = 1'b0;
`endif
        set_d({5'd0, 5'd0, 5'd3, 5'd0}, '0, {5'd0, 5'd0, 5'd0, 5'd3}, 4'b0001, '0);
        #1 check("bundle_raw", BundleHazardD, bh_exp);
        set_d({5'd0, 5'd0, 5'd0, 5'd3}, '0, {5'd0, 5'd0, 5'd3, 5'd0}, 4'b0010, '0);
        #1 check("bundle_raw_reverse", BundleHazardD, 1'b0);

        // Mid-stream reset: forwarding and load stall live, then discarded
        drain();
        set_d('0, '0, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0100, '0);
        tick();
        set_d({5'd0, 5'd0, 5'd0, 5'd5}, '0, {5'd7, 5'd0, 5'd0, 5'd0}, 4'b1000, 4'b1000);
        IFResultM[XLEN*2 +: XLEN] = 64'hAA;
        tick();
        set_d('0, {5'd0, 5'd0, 5'd7, 5'd0}, '0, '0, '0);
        #1;
        check("pre_rst_fwd", {ForwardAE[1:0], FwdLaneAE[1:0], ForwardedSrcAE[31:0]}, {2'b10, 2'd2, 32'hAA});
        check("pre_rst_lu", LoadStallD, 1'b1);
        #1 reset = 1'b1;
        set_d('0, '0, '0, '0, '0);
        #1;
        check("mid_rst_out", {ForwardAE, ForwardBE, FwdLaneAE, FwdLaneBE, RegWriteM, RegWriteW, LoadStallD}, 64'h0);
        check("mid_rst_rd", {RdM, RdW}, 64'h0);
        @(negedge clk) reset = 1'b0;
        tick();
        check("after_rst_out", {ForwardAE, ForwardBE, FwdLaneAE, FwdLaneBE, RegWriteM, RegWriteW, LoadStallD}, 64'h0);
        check("after_rst_rd", {RdM, RdW}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
